// File: rtl/sw_debounce.sv
// sw_debounce
//   Switch conditioning ahead of the blink/counter top level. Each raw switch
//   bit is brought into the clock domain through two flops, then debounced
//   against a prescaled sample tick: a new level is accepted only after it has
//   been seen on STABLE_CNT consecutive ticks. Any tick that sees the input
//   back at the current level throws away the accumulated progress.
//
//   Ports
//     clk_i        system clock, rising edge
//     rst_i        synchronous active-high reset
//     sw_raw_i     raw asynchronous switch inputs
//     sw_o         debounced switch levels (registered)
//     chg_o        one-cycle pulse in the cycle any sw_o bit changes
//     sel_o        index of highest set sw_o bit (0 when none set)
//     sel_valid_o  high when any sw_o bit is set
//     rise_o       per-bit 0->1 pulse, coincident with chg_o
//     fall_o       per-bit 1->0 pulse, coincident with chg_o
//
//   Optional feature
//     SW_DEBOUNCE_EDGE_EN  defined: rise_o/fall_o are registered edge pulses.
//                          undefined: rise_o/fall_o tied low, no edge flops.

module sw_debounce #(
   parameter int WIDTH      = 8,
   parameter int TICK_DIV   = 1000,
   parameter int STABLE_CNT = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [WIDTH-1:0]         sw_raw_i,
   output logic [WIDTH-1:0]         sw_o,
   output logic                     chg_o,
   output logic [$clog2(WIDTH)-1:0] sel_o,
   output logic                     sel_valid_o,
   output logic [WIDTH-1:0]         rise_o,
   output logic [WIDTH-1:0]         fall_o
);

   // A one-cycle prescaler still needs a 1-bit register to stay legal.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam int SW = $clog2(WIDTH);

   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [PW-1:0]    presc;
   logic             tick;
   logic [CW-1:0]    cnt     [WIDTH];
   logic [CW-1:0]    cnt_nxt [WIDTH];
   logic [WIDTH-1:0] flip;

   assign tick = (presc == PRE_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1    <= '0;
         s2    <= '0;
         presc <= '0;
      end else begin
         s1    <= sw_raw_i;
         s2    <= s1;
         presc <= tick ? '0 : presc + PW'(1);
      end
   end

   // flip marks bits whose new value has held for STABLE_CNT ticks; the
   // registered sw_o, chg_o and edge pulses all derive from it so they land
   // in the same cycle.
   always_comb begin
      flip = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (tick) begin
            if (s2[i] == sw_o[i]) begin
               cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               flip[i]    = 1'b1;
               cnt_nxt[i] = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_o  <= '0;
         chg_o <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sw_o  <= sw_o ^ flip;
         chg_o <= |flip;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rise_o <= '0;
         fall_o <= '0;
      end else begin
         rise_o <= flip & ~sw_o;
         fall_o <= flip & sw_o;
      end
   end
`else
   assign rise_o = '0;
   assign fall_o = '0;
`endif

   // Ascending scan: the last set bit seen wins, giving the top bit priority.
   always_comb begin
      sel_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sw_o[i]) begin
            sel_o = SW'(i);
         end
      end
   end

   assign sel_valid_o = |sw_o;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two instances (TICK_DIV=4 and TICK_DIV=1, both
// STABLE_CNT=3, WIDTH=8), each shadowed by a cycle-level model that works
// from the raw input history and the tick schedule; outputs are compared
// every cycle, plus literal expectations at the scenario milestones.

module tb_sw_debounce;

   localparam int W = 8;
`ifdef SW_DEBOUNCE_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst [2];
   logic [W-1:0] raw [2];

   int n_tests = 0;
   int n_fail  = 0;
   int t       = 0;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int TD = (g == 0) ? 4 : 1;
      localparam int SC = 3;

      logic [W-1:0] sw, rise, fall;
      logic         chg, sel_valid;
      logic [2:0]   sel;

      sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
         .clk_i      (clk),
         .rst_i      (rst[g]),
         .sw_raw_i   (raw[g]),
         .sw_o       (sw),
         .chg_o      (chg),
         .sel_o      (sel),
         .sel_valid_o(sel_valid),
         .rise_o     (rise),
         .fall_o     (fall)
      );

      // Model: hist holds the raw values of the last two cycles, so the
      // synchronised view in cycle c is the raw value of cycle c-2. run[b]
      // counts consecutive ticks that disagreed with the accepted level.
      logic [W-1:0] hist [$];
      int           run  [W];
      int           cyc;
      bit           valid = 1'b0;
      logic [W-1:0] s2v, prev;
      logic [W-1:0] e_sw, e_rise, e_fall;
      logic         e_chg, e_valid;
      logic [2:0]   e_sel;

      always @(posedge clk) begin
         if (rst[g]) begin
            hist.delete();
            for (int b = 0; b < W; b++) run[b] = 0;
            cyc    = 0;
            e_sw   = '0;
            e_chg  = 1'b0;
            e_rise = '0;
            e_fall = '0;
            valid  = 1'b1;
         end else begin
            s2v  = (hist.size() == 2) ? hist[0] : '0;
            prev = e_sw;
            if (cyc % TD == TD - 1) begin
               for (int b = 0; b < W; b++) begin
                  if (s2v[b] != prev[b]) begin
                     run[b]++;
                     if (run[b] == SC) begin
                        e_sw[b] = ~prev[b];
                        run[b]  = 0;
                     end
                  end else begin
                     run[b] = 0;
                  end
               end
            end
            e_chg  = (e_sw != prev);
            e_rise = e_sw & ~prev;
            e_fall = ~e_sw & prev;
            if (hist.size() == 2) hist.delete(0);
            hist.push_back(raw[g]);
            cyc++;
         end
         e_valid = (e_sw != '0);
         e_sel   = 3'd0;
         for (int b = W - 1; b >= 0; b--) begin
            if (e_sw[b]) begin
               e_sel = 3'(b);
               break;
            end
         end
      end
   end

   task automatic cmp_inst(input int idx,
                           input logic [W-1:0] a_sw, input logic [W-1:0] x_sw,
                           input logic a_chg, input logic x_chg,
                           input logic [2:0] a_sel, input logic [2:0] x_sel,
                           input logic a_v, input logic x_v,
                           input logic [W-1:0] a_r, input logic [W-1:0] x_r,
                           input logic [W-1:0] a_f, input logic [W-1:0] x_f);
      n_tests++;
      if (a_sw !== x_sw || a_chg !== x_chg || a_sel !== x_sel || a_v !== x_v ||
          a_r !== x_r || a_f !== x_f) begin
         n_fail++;
         $display("FAIL model_inst%0d t=%0t actual/required sw=%h/%h chg=%b/%b sel=%0d/%0d valid=%b/%b rise=%h/%h fall=%h/%h",
                  idx, $time, a_sw, x_sw, a_chg, x_chg, a_sel, x_sel, a_v, x_v, a_r, x_r, a_f, x_f);
      end
   endtask

   always @(negedge clk) begin
      if (u[0].valid)
         cmp_inst(0, u[0].sw, u[0].e_sw, u[0].chg, u[0].e_chg, u[0].sel, u[0].e_sel,
                  u[0].sel_valid, u[0].e_valid, u[0].rise, EDGE ? u[0].e_rise : 8'h00,
                  u[0].fall, EDGE ? u[0].e_fall : 8'h00);
      if (u[1].valid)
         cmp_inst(1, u[1].sw, u[1].e_sw, u[1].chg, u[1].e_chg, u[1].sel, u[1].e_sel,
                  u[1].sel_valid, u[1].e_valid, u[1].rise, EDGE ? u[1].e_rise : 8'h00,
                  u[1].fall, EDGE ? u[1].e_fall : 8'h00);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick_to(input int target);
      while (t < target) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   task automatic do_reset(input int idx);
      rst[idx] = 1'b1;
      @(posedge clk);
      #1;
      rst[idx] = 1'b0;
      t = 0;
   endtask

   initial begin
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      raw[0] = '0;
      raw[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sw",    32'(u[0].sw), 32'h00);
      chk("reset_chg",   32'(u[0].chg), 32'h0);
      chk("reset_valid", 32'(u[0].sel_valid), 32'h0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      t = 0;

      // clean press on bit 0
      raw[0] = 8'h01;
      tick_to(11);
      chk("press_c11_sw", 32'(u[0].sw), 32'h00);
      tick_to(12);
      chk("press_c12_sw",    32'(u[0].sw), 32'h01);
      chk("press_c12_chg",   32'(u[0].chg), 32'h1);
      chk("press_c12_sel",   32'(u[0].sel), 32'h0);
      chk("press_c12_valid", 32'(u[0].sel_valid), 32'h1);
      tick_to(13);
      chk("press_c13_chg", 32'(u[0].chg), 32'h0);

      // reset with the switch still held: level drops, no change pulse
      do_reset(0);
      chk("held_rst_sw",  32'(u[0].sw), 32'h00);
      chk("held_rst_chg", 32'(u[0].chg), 32'h0);
      tick_to(12);
      chk("held_redeb_sw", 32'(u[0].sw), 32'h01);

      // glitch: raw high cycles 0..4 only
      raw[0] = 8'h00;
      do_reset(0);
      raw[0] = 8'h01;
      tick_to(5);
      raw[0] = 8'h00;
      tick_to(20);
      chk("glitch_sw", 32'(u[0].sw), 32'h00);

      // simultaneous bits, then release of bit 6
      do_reset(0);
      raw[0] = 8'h46;
      tick_to(11);
      chk("simul_c11_sw", 32'(u[0].sw), 32'h00);
      tick_to(12);
      chk("simul_sw",   32'(u[0].sw), 32'h46);
      chk("simul_chg",  32'(u[0].chg), 32'h1);
      chk("simul_sel",  32'(u[0].sel), 32'h6);
      chk("simul_rise", 32'(u[0].rise), EDGE ? 32'h46 : 32'h00);
      tick_to(13);
      chk("simul_c13_chg",  32'(u[0].chg), 32'h0);
      chk("simul_c13_rise", 32'(u[0].rise), 32'h00);
      raw[0] = 8'h06;
      tick_to(23);
      chk("release_c23_sw", 32'(u[0].sw), 32'h46);
      tick_to(24);
      chk("release_sw",   32'(u[0].sw), 32'h06);
      chk("release_sel",  32'(u[0].sel), 32'h2);
      chk("release_chg",  32'(u[0].chg), 32'h1);
      chk("release_fall", 32'(u[0].fall), EDGE ? 32'h40 : 32'h00);
      chk("release_rise", 32'(u[0].rise), 32'h00);
      tick_to(25);
      chk("release_c25_fall", 32'(u[0].fall), 32'h00);

      // reset mid-count with bit 7 held
      do_reset(0);
      raw[0] = 8'h80;
      tick_to(9);
      rst[0] = 1'b1;
      tick_to(10);
      rst[0] = 1'b0;
      chk("midrst_sw",    32'(u[0].sw), 32'h00);
      chk("midrst_chg",   32'(u[0].chg), 32'h0);
      chk("midrst_valid", 32'(u[0].sel_valid), 32'h0);
      tick_to(21);
      chk("midrst_n11_sw", 32'(u[0].sw), 32'h00);
      tick_to(22);
      chk("midrst_n12_sw",  32'(u[0].sw), 32'h80);
      chk("midrst_n12_chg", 32'(u[0].chg), 32'h1);
      chk("midrst_n12_sel", 32'(u[0].sel), 32'h7);
      rst[0] = 1'b1;
      tick_to(23);
      rst[0] = 1'b0;
      chk("settled_rst_sw",  32'(u[0].sw), 32'h00);
      chk("settled_rst_chg", 32'(u[0].chg), 32'h0);
      tick_to(24);
      chk("settled_rst_c1_chg", 32'(u[0].chg), 32'h0);

      // TICK_DIV=1 corner on the second instance
      do_reset(1);
      raw[1] = 8'h08;
      tick_to(4);
      chk("td1_c4_sw", 32'(u[1].sw), 32'h00);
      tick_to(5);
      chk("td1_c5_sw",  32'(u[1].sw), 32'h08);
      chk("td1_c5_sel", 32'(u[1].sel), 32'h3);
      chk("td1_c5_chg", 32'(u[1].chg), 32'h1);
      tick_to(6);
      chk("td1_c6_chg", 32'(u[1].chg), 32'h0);

      // TICK_DIV=1 two-tick glitch is rejected
      raw[1] = 8'h00;
      do_reset(1);
      raw[1] = 8'h08;
      tick_to(2);
      raw[1] = 8'h00;
      tick_to(10);
      chk("td1_glitch_sw", 32'(u[1].sw), 32'h00);

      tick_to(14);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
